fir_filter_mc: RTL and testbench

- Multi-channel, time-multiplexed FIR filter. One MAC is shared across NUM_CHANNELS independent sample streams.
- Each channel keeps its own circular delay line. The block has valid/ready handshakes on both sides, runtime history clear, and configurable rounding and saturation of the output.
- It follows on from the single-channel fully parallel FIR and targets low-rate multi-channel paths (e.g. per-antenna decimated streams), where area matters more than throughput.

---
 rtl/fir_mc_pkg.sv | 36 +++
 rtl/fir_mc_if.sv | 28 ++
 rtl/fir_mc_round_sat.sv | 25 ++
 rtl/fir_filter_mc.sv | 158 +++++++++++++++
 tb/tb_fir_filter_mc.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the time-multiplexed multi-channel FIR.
// round_sat works on a fixed wide container so one function serves every width choice.
package fir_mc_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    localparam int SUM_MAX_W = 64;
    localparam logic signed [SUM_MAX_W-1:0] SUM_ONE = 64'sd1;

    function automatic int acc_width(input int in_w, input int coeff_w, input int taps);
        return in_w + coeff_w + $clog2(taps);
    endfunction

    // Returns {sat_flag, value}; the caller keeps the low out_w bits of value.
    function automatic logic [SUM_MAX_W:0] round_sat(
        input logic signed [SUM_MAX_W-1:0] sum,
        input int                          shift,
        input logic                        round,
        input logic                        sat,
        input int                          out_w
    );
        logic signed [SUM_MAX_W-1:0] bias;
        logic signed [SUM_MAX_W-1:0] shifted;
        logic signed [SUM_MAX_W-1:0] max_v;
        logic signed [SUM_MAX_W-1:0] min_v;
        bias = '0;
        if (round && shift > 0) bias = SUM_ONE <<< (shift - 1);
        shifted = (sum + bias) >>> shift;
        max_v   = (SUM_ONE <<< (out_w - 1)) - SUM_ONE;
        min_v   = -(SUM_ONE <<< (out_w - 1));
        if (sat && shifted > max_v) return {1'b1, max_v};
        if (sat && shifted < min_v) return {1'b1, min_v};
        return {1'b0, shifted};
    endfunction

endpackage

// File: rtl/fir_mc_if.sv
// Sample-in / result-out stream bundle of the multi-channel FIR.
// slave is the filter's view, master is the view of whatever feeds and drains it.
interface fir_mc_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int CH_W         = 2
);
    logic                           s_valid;
    logic                           s_ready;
    logic [CH_W-1:0]                s_chan;
    logic signed [INPUT_WIDTH-1:0]  s_data;
    logic                           m_valid;
    logic                           m_ready;
    logic [CH_W-1:0]                m_chan;
    logic signed [OUTPUT_WIDTH-1:0] m_data;
    logic                           m_sat;
    logic                           chan_err;

    modport slave (
        input  s_valid, s_chan, s_data, m_ready,
        output s_ready, m_valid, m_chan, m_data, m_sat, chan_err
    );

    modport master (
        output s_valid, s_chan, s_data, m_ready,
        input  s_ready, m_valid, m_chan, m_data, m_sat, chan_err
    );
endinterface

// File: rtl/fir_mc_round_sat.sv
// Combinational output stage: optional round-half-up, arithmetic shift, optional clamp.
module fir_mc_round_sat
    import fir_mc_pkg::*;
#(
    parameter int ACC_W        = 28,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 7,
    parameter int ROUND        = 1,
    parameter int SATURATE     = 1
) (
    input  logic signed [ACC_W-1:0]        i_sum,
    output logic signed [OUTPUT_WIDTH-1:0] o_data,
    output logic                           o_sat
);
    logic signed [SUM_MAX_W-1:0] w_sum_ext;
    logic [SUM_MAX_W:0]          w_res;
    logic                        w_unused;

    assign w_sum_ext = {{(SUM_MAX_W - ACC_W){i_sum[ACC_W-1]}}, i_sum};
    assign w_res     = round_sat(w_sum_ext, OUT_SHIFT, ROUND != 0, SATURATE != 0, OUTPUT_WIDTH);
    assign o_sat     = w_res[SUM_MAX_W];
    assign o_data    = w_res[OUTPUT_WIDTH-1:0];
    // Upper bits are either a copy of the sign (in range) or wrapped away by design.
    assign w_unused  = ^w_res[SUM_MAX_W-1:OUTPUT_WIDTH];
endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks a channel's circular delay
// line over NUM_TAPS cycles, then rounds/saturates into an output register held until taken.
module fir_filter_mc
    import fir_mc_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int COEFF_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_TAPS     = 16,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{
        -8'sd1, 8'sd0, 8'sd3, 8'sd0, -8'sd9, 8'sd0, 8'sd40, 8'sd64,
        8'sd64, 8'sd40, 8'sd0, -8'sd9, 8'sd0, 8'sd3, 8'sd0, -8'sd1
    },
    parameter int OUT_SHIFT    = 7,
    parameter int ROUND        = 1,
    parameter int SATURATE     = 1
) (
    input logic     clk,
    input logic     rst_n,
    input logic     clr,
    fir_mc_if.slave bus
);
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ACC_W = acc_width(INPUT_WIDTH, COEFF_WIDTH, NUM_TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W:0]   TAPS_EXT = (TAP_W + 1)'(NUM_TAPS);

    state_e r_state;
    state_e w_state_d;

    logic signed [INPUT_WIDTH-1:0]  r_buf [NUM_CHANNELS][NUM_TAPS];
    logic [TAP_W-1:0]               r_wptr [NUM_CHANNELS];
    logic [CH_W-1:0]                r_ch;
    logic [TAP_W-1:0]               r_k;
    logic signed [ACC_W-1:0]        r_acc;
    logic                           r_m_valid;
    logic [CH_W-1:0]                r_m_chan;
    logic signed [OUTPUT_WIDTH-1:0] r_m_data;
    logic                           r_m_sat;
    logic                           r_chan_err;

    logic                           w_chan_ok;
    logic                           w_last;
    logic [TAP_W-1:0]               w_cur_wptr;
    logic [TAP_W-1:0]               w_rd_idx;
    logic [TAP_W-1:0]               w_wptr_inc;
    logic signed [INPUT_WIDTH-1:0]  w_tap;
    logic signed [ACC_W-1:0]        w_tap_ext;
    logic signed [ACC_W-1:0]        w_coef_ext;
    logic signed [ACC_W-1:0]        w_acc_sum;
    logic signed [OUTPUT_WIDTH-1:0] w_rs_data;
    logic                           w_rs_sat;

    // Zero-extend before comparing so a power-of-two channel count stays lint-clean.
    assign w_chan_ok  = {{(32 - CH_W){1'b0}}, bus.s_chan} < 32'(NUM_CHANNELS);
    assign w_cur_wptr = r_wptr[r_ch];
    assign w_rd_idx   = (w_cur_wptr >= r_k) ? w_cur_wptr - r_k
                      : TAP_W'({1'b0, w_cur_wptr} + TAPS_EXT - {1'b0, r_k});
    assign w_tap      = r_buf[r_ch][w_rd_idx];
    assign w_tap_ext  = {{(ACC_W - INPUT_WIDTH){w_tap[INPUT_WIDTH-1]}}, w_tap};
    assign w_coef_ext = {{(ACC_W - COEFF_WIDTH){COEFFS[r_k][COEFF_WIDTH-1]}}, COEFFS[r_k]};
    assign w_acc_sum  = r_acc + w_tap_ext * w_coef_ext;
    assign w_last     = (r_k == LAST_TAP);
    assign w_wptr_inc = (w_cur_wptr == LAST_TAP) ? '0 : w_cur_wptr + 1'b1;

    fir_mc_round_sat #(
        .ACC_W        (ACC_W),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .OUT_SHIFT    (OUT_SHIFT),
        .ROUND        (ROUND),
        .SATURATE     (SATURATE)
    ) u_round_sat (
        .i_sum  (w_acc_sum),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (bus.s_valid && w_chan_ok) w_state_d = MAC;
            MAC:     if (w_last) w_state_d = OUT;
            OUT:     if (bus.m_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
        if (clr) w_state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wptr[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) r_buf[c][t] <= '0;
            end
            r_ch       <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_m_valid  <= 1'b0;
            r_m_chan   <= '0;
            r_m_data   <= '0;
            r_m_sat    <= 1'b0;
            r_chan_err <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wptr[c] <= '0;
                for (int t = 0; t < NUM_TAPS; t++) r_buf[c][t] <= '0;
            end
            r_m_valid  <= 1'b0;
            r_chan_err <= 1'b0;
        end else begin
            r_chan_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.s_valid && w_chan_ok) begin
                        r_buf[bus.s_chan][r_wptr[bus.s_chan]] <= bus.s_data;
                        r_ch  <= bus.s_chan;
                        r_acc <= '0;
                        r_k   <= '0;
                    end else if (bus.s_valid) begin
                        r_chan_err <= 1'b1;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_sum;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_m_valid <= 1'b1;
                        r_m_chan  <= r_ch;
                        r_m_data  <= w_rs_data;
                        r_m_sat   <= w_rs_sat;
                    end
                end
                OUT: begin
                    // The pointer advances only once the result is taken.
                    if (bus.m_ready) begin
                        r_m_valid    <= 1'b0;
                        r_wptr[r_ch] <= w_wptr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready  = (r_state == IDLE);
    assign bus.m_valid  = r_m_valid;
    assign bus.m_chan   = r_m_chan;
    assign bus.m_data   = r_m_data;
    assign bus.m_sat    = r_m_sat;
    assign bus.chan_err = r_chan_err;
endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: a newest-first history model predicts every output, a compare
// process checks the DUT each cycle, and directed scenarios pin literal results.
module tb_fir_filter_mc;
    // Five channels so that s_chan=5 is representable yet out of range.
    localparam int NCH   = 5;
    localparam int NTAPS = 16;
    localparam int CHW   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr   = 1'b0;

    fir_mc_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16), .CH_W(CHW)) bus ();

    fir_filter_mc #(.NUM_CHANNELS(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int data; int sat; int acc_cyc; } exp_t;
    typedef struct { int ch; int data; int sat; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    exp_t cur;
    int   coef    [NTAPS] = '{-1, 0, 3, 0, -9, 0, 40, 64, 64, 40, 0, -9, 0, 3, 0, -1};
    int   imp_ref [NTAPS] = '{-1, 0, 3, 0, -9, 0, 40, 64, 64, 40, 0, -9, 0, 3, 0, -1};
    int   hist    [NCH][NTAPS];
    int   cyc      = 0;
    int   err_at   = -10;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Round half up by 2^6, floor-divide by 2^7, clamp to 16-bit signed.
    function automatic void model_rs(input longint sum, output int val, output int sat);
        longint q;
        q = (sum + 64) >>> 7;
        if (q > 32767) begin
            val = 32767;  sat = 1;
        end else if (q < -32768) begin
            val = -32768; sat = 1;
        end else begin
            val = int'(q); sat = 0;
        end
    endfunction

    task automatic model_accept(input int ch, input int data);
        longint sum;
        int     v;
        int     s;
        if (ch >= NCH) begin
            err_at = cyc;
            return;
        end
        for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = data;
        sum = 0;
        for (int k = 0; k < NTAPS; k++) sum += longint'(hist[ch][k]) * coef[k];
        model_rs(sum, v, s);
        exp_q.push_back('{ch, v, s, cyc});
    endtask

    task automatic model_flush();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) hist[c][k] = 0;
        exp_q.delete();
        err_at = -10;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ch, input int data);
        int n = 0;
        while (!bus.s_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("s_ready before send", bus.s_ready, 1);
        if (!bus.s_ready) return;
        bus.s_valid = 1'b1;
        bus.s_chan  = CHW'(ch);
        bus.s_data  = 16'(data);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        model_accept(ch, data);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("drain pending outputs", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"},  bus.s_ready,  1);
        check({tag, " m_valid"},  bus.m_valid,  0);
        check({tag, " m_chan"},   bus.m_chan,   0);
        check({tag, " m_data"},   bus.m_data,   0);
        check({tag, " m_sat"},    bus.m_sat,    0);
        check({tag, " chan_err"}, bus.chan_err, 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_flush();
    endtask

    task automatic run_impulse(input string tag);
        int q[$];
        obs_q.delete();
        send(0, 128);
        for (int i = 1; i < NTAPS; i++) send(0, 0);
        drain();
        foreach (obs_q[i]) if (obs_q[i].ch == 0) q.push_back(obs_q[i].data);
        check({tag, " ch0 output count"}, q.size(), NTAPS);
        for (int i = 0; i < NTAPS && i < q.size(); i++)
            check($sformatf("%s impulse[%0d]", tag, i), q[i], imp_ref[i]);
    endtask

    // Compare process: every cycle with live outputs is checked against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("chan_err", bus.chan_err, (err_at == cyc) ? 1 : 0);
            if (bus.m_valid && exp_q.size() == 0) begin
                check("m_valid with nothing pending", bus.m_valid, 0);
            end else if (bus.m_valid) begin
                cur = exp_q[0];
                if (!prev_valid) check("latency accept->m_valid", cyc - cur.acc_cyc, NTAPS);
                check("m_chan", bus.m_chan, cur.ch);
                check("m_data", bus.m_data, cur.data);
                check("m_sat", bus.m_sat, cur.sat);
                check("s_ready while holding", bus.s_ready, 0);
                if (bus.m_ready) begin
                    obs_q.push_back('{int'(bus.m_chan), int'(bus.m_data), int'(bus.m_sat)});
                    void'(exp_q.pop_front());
                end
            end
            prev_valid = bus.m_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        int s;
        bus.s_valid = 1'b0;
        bus.s_chan  = '0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        // Pin the model against hand-computed values.
        model_rs(6356798, v, s);  check("model +sat value", v, 32767);  check("model +sat flag", s, 1);
        model_rs(-6356992, v, s); check("model -sat value", v, -32768); check("model -sat flag", s, 1);
        model_rs(5120, v, s);     check("model 128*40", v, 40);         check("model 128*40 sat", s, 0);
        model_rs(-128, v, s);     check("model 128*-1", v, -1);

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("in reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_outputs("after reset");

        // Impulse response on ch0.
        run_impulse("scn1");

        // Positive then negative saturation on ch1.
        obs_q.delete();
        for (int i = 0; i < NTAPS; i++) send(1, 32767);
        drain();
        check("scn2 +16th data", obs_q[obs_q.size()-1].data, 32767);
        check("scn2 +16th sat", obs_q[obs_q.size()-1].sat, 1);
        obs_q.delete();
        for (int i = 0; i < NTAPS; i++) send(1, -32768);
        drain();
        check("scn2 -16th data", obs_q[obs_q.size()-1].data, -32768);
        check("scn2 -16th sat", obs_q[obs_q.size()-1].sat, 1);

        // Channel isolation: ch0 impulse interleaved with zeros on ch2/ch3.
        pulse_clr();
        obs_q.delete();
        for (int i = 0; i < NTAPS; i++) begin
            send(0, (i == 0) ? 128 : 0);
            send(2, 0);
            send(3, 0);
        end
        drain();
        begin
            int q0[$];
            int n23 = 0;
            foreach (obs_q[i]) begin
                if (obs_q[i].ch == 0) q0.push_back(obs_q[i].data);
                else begin
                    n23++;
                    check("scn3 ch2/ch3 zero", obs_q[i].data, 0);
                end
            end
            check("scn3 ch2/ch3 count", n23, 2 * NTAPS);
            check("scn3 ch0 count", q0.size(), NTAPS);
            for (int i = 0; i < NTAPS && i < q0.size(); i++)
                check($sformatf("scn3 impulse[%0d]", i), q0[i], imp_ref[i]);
        end

        // Backpressure with a sample waiting on the input side.
        bus.m_ready = 1'b0;
        send(0, 1000);
        begin
            int n = 0;
            while (!bus.m_valid && n < 40) begin
                @(posedge clk); #1; n++;
            end
        end
        check("scn4 m_valid rose", bus.m_valid, 1);
        bus.s_valid = 1'b1;
        bus.s_chan  = CHW'(3);
        bus.s_data  = 16'(77);
        repeat (5) begin
            @(posedge clk); #1;
            check("scn4 held s_ready", bus.s_ready, 0);
            check("scn4 held m_valid", bus.m_valid, 1);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        check("scn4 after handshake m_valid", bus.m_valid, 0);
        check("scn4 after handshake s_ready", bus.s_ready, 1);
        @(posedge clk); #1;
        check("scn4 accepted next cycle", bus.s_ready, 0);
        bus.s_valid = 1'b0;
        model_accept(3, 77);
        drain();

        // Out-of-range channel: dropped with a single chan_err pulse.
        send(5, 123);
        check("scn5 bad chan s_ready", bus.s_ready, 1);
        repeat (20) @(posedge clk);
        #1;

        // clr mid-MAC discards the in-flight sample.
        send(0, 128);
        repeat (5) @(posedge clk);
        #1 pulse_clr();
        check("scn5 s_ready after clr", bus.s_ready, 1);
        repeat (25) @(posedge clk);
        #1 run_impulse("scn5");

        // Leave non-reset values on the outputs, then reset at k=7.
        send(1, -32768);
        drain();
        send(0, 128);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid-MAC reset");
        model_flush();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_outputs("after mid-MAC reset");
        repeat (20) @(posedge clk);
        #1 run_impulse("scn6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
